maj_tt_sequencer: RTL and testbench

MAJ_TT_SEQUENCER -- requirements
Module: maj_tt_sequencer

---
 rtl/maj_tt_pkg.sv | 45 ++++
 rtl/maj_tt_sequencer_if.sv | 27 ++
 rtl/maj3_unit.sv | 29 ++
 rtl/maj_tt_sequencer.sv | 140 ++++++++++++++
 tb/tb_maj_tt_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/maj_tt_pkg.sv
// Shared constants, select encoding, gate descriptor and FSM state for the
// MAJ3 truth-table sequencer. Optional feature macro: MAJ_INV_EN.
package maj_tt_pkg;

  localparam int NUM_INPUTS = 7;
  localparam int NUM_GATES  = 6;
  localparam int TT_W       = 128;
  localparam int SEL_W      = 4;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_ZERO = 4'd0;
  localparam sel_t SEL_X0   = 4'd1;
  localparam sel_t SEL_X6   = 4'd7;
  localparam sel_t SEL_W0   = 4'd8;
  localparam sel_t SEL_W5   = 4'd13;

`ifdef MAJ_INV_EN
  typedef struct packed {
    logic [2:0] inv;
    sel_t       c;
    sel_t       b;
    sel_t       a;
  } gate_t;
`else
  typedef struct packed {
    sel_t c;
    sel_t b;
    sel_t a;
  } gate_t;
`endif

  localparam int GATE_W = $bits(gate_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2:0] clamp_n(logic [2:0] v);
    return (v > 3'(NUM_GATES)) ? 3'(NUM_GATES) : v;
  endfunction

endpackage

// File: rtl/maj_tt_sequencer_if.sv
// Config/control bundle of the sequencer. master = host, slave = sequencer.
// cfg_we/addr/gate/ngates/start in, busy/done/tt out.
interface maj_tt_sequencer_if;
  import maj_tt_pkg::*;

  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [GATE_W-1:0] cfg_gate;
  logic [2:0]        cfg_ngates;
  logic              start;
  logic              busy;
  logic              done;
  logic [TT_W-1:0]   tt;

  modport master (
    output cfg_we, cfg_addr, cfg_gate,
    output cfg_ngates, start,
    input  busy, done, tt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_gate,
    input  cfg_ngates, start,
    output busy, done, tt
  );

endinterface

// File: rtl/maj3_unit.sv
// Shared combinational MAJ3; with MAJ_INV_EN each operand may be complemented.
// Ports: a,b,c operands, inv={ic,ib,ia} (MAJ_INV_EN only), y result.
module maj3_unit (
  input  logic       a,
  input  logic       b,
  input  logic       c,
`ifdef MAJ_INV_EN
  input  logic [2:0] inv,
`endif
  output logic       y
);

  logic a_e;
  logic b_e;
  logic c_e;

`ifdef MAJ_INV_EN
  assign a_e = a ^ inv[0];
  assign b_e = b ^ inv[1];
  assign c_e = c ^ inv[2];
`else
  assign a_e = a;
  assign b_e = b;
  assign c_e = c;
`endif

  assign y = (a_e & b_e) | (a_e & c_e) | (b_e & c_e);

endmodule

// File: rtl/maj_tt_sequencer.sv
// Evaluates a 6-gate MAJ3 network over all 128 input patterns, one gate per
// cycle. Ports: clk, rst_n, bus (slave). Optional macro: MAJ_INV_EN.
module maj_tt_sequencer
  import maj_tt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  maj_tt_sequencer_if.slave bus
);

  state_t                state;
  gate_t                 prog [NUM_GATES];
  logic [NUM_GATES-1:0]  w;
  logic [6:0]            p;
  logic [2:0]            g;
  logic [2:0]            n;
  logic                  busy_q;
  logic                  done_q;
  logic [TT_W-1:0]       tt_q;

  gate_t cur;
  logic  opa;
  logic  opb;
  logic  opc;
  logic  res;

  // Node k is only visible to gates after it; anything else reads 0.
  function automatic logic operand(
    sel_t                 sel,
    logic [6:0]           pat,
    logic [NUM_GATES-1:0] nodes,
    logic [2:0]           gi
  );
    logic       r;
    logic [3:0] idx;
    r   = 1'b0;
    idx = 4'd0;
    unique case (1'b1)
      (sel >= SEL_X0 && sel <= SEL_X6): begin
        idx = sel - SEL_X0;
        r   = pat[idx[2:0]];
      end
      (sel >= SEL_W0 && sel <= SEL_W5): begin
        idx = sel - SEL_W0;
        r   = (idx[2:0] < gi) ? nodes[idx[2:0]] : 1'b0;
      end
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cur = prog[g];
  assign opa = operand(cur.a, p, w, g);
  assign opb = operand(cur.b, p, w, g);
  assign opc = operand(cur.c, p, w, g);

  maj3_unit u_maj3 (
    .a   (opa),
    .b   (opb),
    .c   (opc),
`ifdef MAJ_INV_EN
    .inv (cur.inv),
`endif
    .y   (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GATES; i++) begin
        prog[i] <= '0;
      end
    end else if (bus.cfg_we && !busy_q &&
                 bus.cfg_addr < 3'(NUM_GATES)) begin
      prog[bus.cfg_addr] <= gate_t'(bus.cfg_gate);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tt_q   <= '0;
      p      <= '0;
      g      <= '0;
      w      <= '0;
      n      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            n <= clamp_n(bus.cfg_ngates);
            p <= '0;
            g <= '0;
            w <= '0;
            if (bus.cfg_ngates == 3'd0) begin
              tt_q   <= '0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= EVAL;
            end
          end
        end
        EVAL: begin
          w[g] <= res;
          if (g == n - 3'd1) begin
            tt_q[p] <= res;
            g       <= '0;
            w       <= '0;
            if (p == 7'd127) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              p <= p + 7'd1;
            end
          end else begin
            g <= g + 3'd1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tt   = tt_q;

endmodule

// File: tb/tb_maj_tt_sequencer.sv
// Scoreboard bench for maj_tt_sequencer: directed programs, expected tt,
// done latency and busy length queued at start, checked on done.
module tb_maj_tt_sequencer;
  import maj_tt_pkg::*;

  localparam logic [127:0] TT_8 = {32{4'h8}};
  localparam logic [127:0] TT_A = {32{4'hA}};
  localparam logic [127:0] TT_E = {32{4'hE}};
  localparam logic [127:0] TT_E8 = {16{8'hE8}};
  localparam logic [127:0] TT_HI =
    128'hFFFF_FFFF_FFFF_0000_FFFF_0000_0000_0000;

  localparam sel_t Z  = 4'd0;
  localparam sel_t X0 = 4'd1;
  localparam sel_t X1 = 4'd2;
  localparam sel_t X2 = 4'd3;
  localparam sel_t X4 = 4'd5;
  localparam sel_t X5 = 4'd6;
  localparam sel_t X6 = 4'd7;
  localparam sel_t W0 = 4'd8;
  localparam sel_t W1 = 4'd9;

  typedef struct {
    logic [127:0] tt;
    int           lat;
    int           busy;
    int           start;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   bcnt;
  exp_t sb [$];

  maj_tt_sequencer_if bif ();

  maj_tt_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [GATE_W-1:0] mk(sel_t a, sel_t b, sel_t c);
`ifdef MAJ_INV_EN
    return {3'b000, c, b, a};
`else
    return {c, b, a};
`endif
  endfunction

`ifdef MAJ_INV_EN
  function automatic logic [GATE_W-1:0] mki(
    logic [2:0] inv, sel_t a, sel_t b, sel_t c
  );
    return {inv, c, b, a};
  endfunction
`endif

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bcnt = 0;
    end else begin
      if (bif.busy) bcnt++;
      if (bif.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (bif.tt !== e.tt) begin
            errors++;
            $display("FAIL tt got %h exp %h", bif.tt, e.tt);
          end
          checks++;
          if (cyc - e.start != e.lat) begin
            errors++;
            $display("FAIL done_latency got %0d exp %0d",
                     cyc - e.start, e.lat);
          end
          checks++;
          if (bcnt != e.busy) begin
            errors++;
            $display("FAIL busy_cycles got %0d exp %0d", bcnt, e.busy);
          end
        end
        bcnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [GATE_W-1:0] gv);
    bif.cfg_we   = 1'b1;
    bif.cfg_addr = addr;
    bif.cfg_gate = gv;
    tick();
    bif.cfg_we   = 1'b0;
  endtask

  task automatic push(
    input logic [127:0] ett, input int elat, input int ebusy
  );
    exp_t e;
    e.tt    = ett;
    e.lat   = elat;
    e.busy  = ebusy;
    e.start = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 5000 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL done_timeout pending %0d exp 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(
    input logic [2:0] ng, input logic [127:0] ett,
    input int elat, input int ebusy
  );
    bif.cfg_ngates = ng;
    bif.start      = 1'b1;
    push(ett, elat, ebusy);
    tick();
    bif.start = 1'b0;
    wait_empty();
  endtask

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  initial begin
    cyc            = 0;
    checks         = 0;
    errors         = 0;
    bcnt           = 0;
    rst_n          = 1'b0;
    bif.cfg_we     = 1'b0;
    bif.cfg_addr   = '0;
    bif.cfg_gate   = '0;
    bif.cfg_ngates = '0;
    bif.start      = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 128'(bif.busy), 128'd0);
    chk("rst_done", 128'(bif.done), 128'd0);
    chk("rst_tt", bif.tt, 128'd0);
    rst_n = 1'b1;
    tick();

    wr(3'd0, mk(X0, X1, Z));
    run(3'd1, TT_8, 129, 128);

    wr(3'd0, mk(X0, X1, X2));
    run(3'd1, TT_E8, 129, 128);

    wr(3'd1, mk(W0, W0, Z));
    run(3'd2, TT_E8, 257, 256);

    run(3'd0, 128'd0, 1, 0);

    for (int k = 2; k < 6; k++) begin
      wr(3'(k), mk(sel_t'(W0 + 4'(k - 1)), sel_t'(W0 + 4'(k - 1)), Z));
    end
    wr(3'd6, mk(X0, X1, Z));
    run(3'd7, TT_E8, 769, 768);

    wr(3'd0, mk(X4, X5, X6));
    run(3'd1, TT_HI, 129, 128);

    wr(3'd0, mk(W1, X0, X0));
    run(3'd1, TT_A, 129, 128);

    wr(3'd0, mk(W0, X0, X1));
    run(3'd1, TT_8, 129, 128);

    // config write in the same cycle as the start
    bif.cfg_we     = 1'b1;
    bif.cfg_addr   = 3'd0;
    bif.cfg_gate   = mk(X0, X1, X2);
    bif.cfg_ngates = 3'd1;
    bif.start      = 1'b1;
    push(TT_E8, 129, 128);
    tick();
    bif.cfg_we = 1'b0;
    bif.start  = 1'b0;
    wait_empty();

    // start and cfg_we while busy are dropped
    bif.cfg_ngates = 3'd1;
    bif.start      = 1'b1;
    push(TT_E8, 129, 128);
    tick();
    bif.start = 1'b0;
    repeat (20) tick();
    bif.cfg_ngates = 3'd2;
    bif.start      = 1'b1;
    bif.cfg_we     = 1'b1;
    bif.cfg_addr   = 3'd0;
    bif.cfg_gate   = mk(Z, Z, Z);
    tick();
    bif.start  = 1'b0;
    bif.cfg_we = 1'b0;
    wait_empty();
    run(3'd1, TT_E8, 129, 128);

    // reset in the middle of evaluation
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    repeat (49) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_tt", bif.tt, 128'd0);
    chk("abort_busy", 128'(bif.busy), 128'd0);
    chk("abort_done", 128'(bif.done), 128'd0);
    tick();
    rst_n = 1'b1;
    repeat (200) tick();
    chk("post_abort_tt", bif.tt, 128'd0);
    wr(3'd0, mk(X0, X1, X2));
    run(3'd1, TT_E8, 129, 128);

`ifdef MAJ_INV_EN
    wr(3'd0, mki(3'b001, Z, X0, X1));
    run(3'd1, TT_E, 129, 128);
`else
    chk("tt_not_e", 128'(bif.tt == TT_E), 128'd0);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
